// File: rtl/ifq_multi_port_if.sv
// Port bundle of the instruction fetch queue: predictor allocation, icache responses, decoder issue.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface ifq_multi_port_if #(
   parameter int unsigned FETCH_W   = 4,
   parameter int unsigned NUM_RES   = 2,
   parameter int unsigned RES_WORDS = 2,
   parameter int unsigned VADDR_W   = 39,
   parameter int unsigned PADDR_W   = 56,
   parameter int unsigned ID_W      = 32
);
   logic                           flush;
   logic [31:0]                    generation;
   logic                           alloc_valid;
   logic                           alloc_ready;
   logic [VADDR_W-1:0]             alloc_vaddr;
   logic [ID_W-1:0]                alloc_id;
   logic [FETCH_W-1:0]             alloc_taken;
   logic [FETCH_W-1:0]             alloc_btb_hit;
   logic [FETCH_W*VADDR_W-1:0]     alloc_btb_addr;
   logic                           redirect_valid;
   logic [VADDR_W-1:0]             redirect_addr;
   logic [NUM_RES-1:0]             res_valid;
   logic [NUM_RES*ID_W-1:0]        res_id;
   logic [NUM_RES*32-1:0]          res_gen;
   logic [NUM_RES*VADDR_W-1:0]     res_vaddr;
   logic [NUM_RES*PADDR_W-1:0]     res_paddr;
   logic [NUM_RES-1:0]             res_pf;
   logic [NUM_RES-1:0]             res_af;
   logic [NUM_RES*RES_WORDS*32-1:0] res_data;
   logic                           out_valid;
   logic                           out_ready;
   logic [FETCH_W-1:0]             out_slot_valid;
   logic [FETCH_W*VADDR_W-1:0]     out_vaddr;
   logic [FETCH_W*PADDR_W-1:0]     out_paddr;
   logic [FETCH_W*32-1:0]          out_data;
   logic [FETCH_W-1:0]             out_taken;
   logic [FETCH_W-1:0]             out_btb_hit;
   logic [FETCH_W*VADDR_W-1:0]     out_btb_addr;
   logic [FETCH_W-1:0]             out_pf;
   logic [FETCH_W-1:0]             out_af;

   modport master (
      output flush, generation, alloc_valid, alloc_vaddr, alloc_id, alloc_taken, alloc_btb_hit,
             alloc_btb_addr, res_valid, res_id, res_gen, res_vaddr, res_paddr, res_pf, res_af,
             res_data, out_ready,
      input  alloc_ready, redirect_valid, redirect_addr, out_valid, out_slot_valid, out_vaddr,
             out_paddr, out_data, out_taken, out_btb_hit, out_btb_addr, out_pf, out_af
   );

   modport slave (
      input  flush, generation, alloc_valid, alloc_vaddr, alloc_id, alloc_taken, alloc_btb_hit,
             alloc_btb_addr, res_valid, res_id, res_gen, res_vaddr, res_paddr, res_pf, res_af,
             res_data, out_ready,
      output alloc_ready, redirect_valid, redirect_addr, out_valid, out_slot_valid, out_vaddr,
             out_paddr, out_data, out_taken, out_btb_hit, out_btb_addr, out_pf, out_af
   );
endinterface

// File: rtl/ifq_multi_port.sv
// Instruction fetch queue: predictor-allocated entries, out-of-order multi-port icache fill, in-order
// issue. Define IFQ_PARTIAL_ISSUE_EN to issue received slot prefixes before the head entry completes.
module ifq_multi_port #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned FETCH_W   = 4,
   parameter int unsigned NUM_RES   = 2,
   parameter int unsigned RES_WORDS = 2,
   parameter int unsigned VADDR_W   = 39,
   parameter int unsigned PADDR_W   = 56,
   parameter int unsigned ID_W      = 32
) (
   input logic             clock,
   input logic             reset,
   ifq_multi_port_if.slave bus
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   typedef logic [FETCH_W-1:0] mask_t;

   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [VADDR_W-1:0] base_q [DEPTH], base_d [DEPTH];
   logic [ID_W-3:0]    tag_q [DEPTH], tag_d [DEPTH];
   mask_t              slot_q [DEPTH], slot_d [DEPTH], taken_q [DEPTH], taken_d [DEPTH];
   mask_t              hit_q [DEPTH], hit_d [DEPTH], recv_q [DEPTH], recv_d [DEPTH];
   mask_t              pf_q [DEPTH], pf_d [DEPTH], af_q [DEPTH], af_d [DEPTH];
   logic [VADDR_W-1:0] btb_q [DEPTH][FETCH_W], btb_d [DEPTH][FETCH_W];
   logic [31:0]        data_q [DEPTH][FETCH_W], data_d [DEPTH][FETCH_W];
   logic [PADDR_W-1:0] paddr_q [DEPTH][FETCH_W], paddr_d [DEPTH][FETCH_W];
   logic [PtrW-1:0]    rp_q, rp_d, wp_q, wp_d;
   logic [CntW-1:0]    count_q, count_d;
   logic               redir_valid_q, redir_valid_d;
   logic [VADDR_W-1:0] redir_addr_q, redir_addr_d;
`ifdef IFQ_PARTIAL_ISSUE_EN
   mask_t              iss_q [DEPTH], iss_d [DEPTH];
`endif

   logic               alloc_fire, out_valid, issue, pop, alloc_redirect, unused_bits;
   mask_t              alloc_slots, head_avail;
   logic [VADDR_W-1:0] alloc_target;

   assign bus.alloc_ready = (count_q != CntW'(DEPTH));
   assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
   assign unused_bits     = ^{bus.alloc_id[1:0], bus.res_id};

   // Valid slots run up to and including the first predicted-taken BTB hit.
   always_comb begin
      alloc_slots    = '0;
      alloc_redirect = 1'b0;
      alloc_target   = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         if (!alloc_redirect) begin
            alloc_slots[i] = 1'b1;
            if (bus.alloc_taken[i] && bus.alloc_btb_hit[i]) begin
               alloc_redirect = 1'b1;
               alloc_target   = bus.alloc_btb_addr[i*VADDR_W +: VADDR_W];
            end
         end
      end
   end

`ifdef IFQ_PARTIAL_ISSUE_EN
   // Offer the received run starting at the lowest unissued valid slot.
   always_comb begin
      logic stop;
      stop       = 1'b0;
      head_avail = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         if (slot_q[rp_q][i] && !iss_q[rp_q][i]) begin
            if (!stop && recv_q[rp_q][i]) head_avail[i] = 1'b1;
            else                          stop = 1'b1;
         end
      end
   end
   assign pop = issue && ((slot_q[rp_q] & ~(iss_q[rp_q] | head_avail)) == '0);
`else
   assign head_avail = ((slot_q[rp_q] & ~recv_q[rp_q]) == '0) ? slot_q[rp_q] : '0;
   assign pop        = issue;
`endif

   assign out_valid = (count_q != '0) && (head_avail != '0);
   assign issue     = out_valid && bus.out_ready;

   always_comb begin
      logic               res_ok;
      logic [ID_W-3:0]    res_tag;
      logic [VADDR_W-1:0] w_vaddr;
      logic [PADDR_W-1:0] w_paddr;
      logic [31:0]        w_data;
      res_ok = 1'b0; res_tag = '0; w_vaddr = '0; w_paddr = '0; w_data = '0;
      valid_d = valid_q; base_d = base_q; tag_d = tag_q; slot_d = slot_q; taken_d = taken_q;
      hit_d = hit_q; recv_d = recv_q; pf_d = pf_q; af_d = af_q; btb_d = btb_q;
      data_d = data_q; paddr_d = paddr_q;
`ifdef IFQ_PARTIAL_ISSUE_EN
      iss_d = iss_q;
`endif
      rp_d = rp_q; wp_d = wp_q;
      redir_valid_d = 1'b0;
      redir_addr_d  = redir_addr_q;
      if (alloc_fire) begin
         valid_d[wp_q] = 1'b1;
         base_d[wp_q]  = bus.alloc_vaddr;
         tag_d[wp_q]   = bus.alloc_id[ID_W-1:2];
         slot_d[wp_q]  = alloc_slots;
         taken_d[wp_q] = bus.alloc_taken;
         hit_d[wp_q]   = bus.alloc_btb_hit;
         recv_d[wp_q]  = '0;
         pf_d[wp_q]    = '0;
         af_d[wp_q]    = '0;
`ifdef IFQ_PARTIAL_ISSUE_EN
         iss_d[wp_q]   = '0;
`endif
         for (int i = 0; i < FETCH_W; i++) btb_d[wp_q][i] = bus.alloc_btb_addr[i*VADDR_W +: VADDR_W];
         wp_d          = wp_q + PtrW'(1);
         redir_valid_d = alloc_redirect;
         if (alloc_redirect) redir_addr_d = alloc_target;
      end
      // Later ports overwrite earlier ones; the entry allocated this cycle is already live.
      for (int p = 0; p < NUM_RES; p++) begin
         res_ok  = bus.res_valid[p] && (bus.res_gen[p*32 +: 32] == bus.generation);
         res_tag = bus.res_id[p*ID_W+2 +: ID_W-2];
         for (int w = 0; w < RES_WORDS; w++) begin
            w_vaddr = bus.res_vaddr[p*VADDR_W +: VADDR_W] + VADDR_W'(4 * w);
            w_paddr = bus.res_paddr[p*PADDR_W +: PADDR_W] + PADDR_W'(4 * w);
            w_data  = bus.res_data[(p*RES_WORDS+w)*32 +: 32];
            for (int e = 0; e < DEPTH; e++) begin
               for (int i = 0; i < FETCH_W; i++) begin
                  if (res_ok && valid_d[e] && tag_d[e] == res_tag &&
                      base_d[e] + VADDR_W'(4 * i) == w_vaddr) begin
                     recv_d[e][i]  = 1'b1;
                     data_d[e][i]  = w_data;
                     paddr_d[e][i] = w_paddr;
                     pf_d[e][i]    = bus.res_pf[p];
                     af_d[e][i]    = bus.res_af[p];
                  end
               end
            end
         end
      end
`ifdef IFQ_PARTIAL_ISSUE_EN
      if (issue) iss_d[rp_q] = iss_q[rp_q] | head_avail;
`endif
      if (pop) begin
         valid_d[rp_q] = 1'b0;
         rp_d          = rp_q + PtrW'(1);
      end
      count_d = count_q + CntW'(alloc_fire) - CntW'(pop);
      if (bus.flush) begin
         valid_d       = '0;
         rp_d          = '0;
         wp_d          = '0;
         count_d       = '0;
         redir_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q       <= '0;
         rp_q          <= '0;
         wp_q          <= '0;
         count_q       <= '0;
         redir_valid_q <= 1'b0;
         redir_addr_q  <= '0;
      end else begin
         valid_q       <= valid_d;
         rp_q          <= rp_d;
         wp_q          <= wp_d;
         count_q       <= count_d;
         redir_valid_q <= redir_valid_d;
         redir_addr_q  <= redir_addr_d;
      end
   end

   // Payload is qualified by valid_q/count_q, so it needs no reset.
   always_ff @(posedge clock) begin
      base_q  <= base_d;  tag_q  <= tag_d;  slot_q <= slot_d; taken_q <= taken_d;
      hit_q   <= hit_d;   recv_q <= recv_d; pf_q   <= pf_d;   af_q    <= af_d;
      btb_q   <= btb_d;   data_q <= data_d; paddr_q <= paddr_d;
`ifdef IFQ_PARTIAL_ISSUE_EN
      iss_q   <= iss_d;
`endif
   end

   assign bus.redirect_valid = redir_valid_q;
   assign bus.redirect_addr  = redir_addr_q;
   assign bus.out_valid      = out_valid;
   assign bus.out_slot_valid = head_avail;
   assign bus.out_taken      = taken_q[rp_q];
   assign bus.out_btb_hit    = hit_q[rp_q];
   assign bus.out_pf         = pf_q[rp_q];
   assign bus.out_af         = af_q[rp_q];

   always_comb begin
      bus.out_vaddr    = '0;
      bus.out_paddr    = '0;
      bus.out_data     = '0;
      bus.out_btb_addr = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         bus.out_vaddr[i*VADDR_W +: VADDR_W]    = base_q[rp_q] + VADDR_W'(4 * i);
         bus.out_paddr[i*PADDR_W +: PADDR_W]    = paddr_q[rp_q][i];
         bus.out_data[i*32 +: 32]               = data_q[rp_q][i];
         bus.out_btb_addr[i*VADDR_W +: VADDR_W] = btb_q[rp_q][i];
      end
   end
endmodule

// File: tb/tb_ifq_multi_port.sv
// Bench for ifq_multi_port: directed scenarios then random traffic, all checked against a
// queue-of-entries reference model. Honours IFQ_PARTIAL_ISSUE_EN.
module tb_ifq_multi_port;
   localparam int FW = 4, NR = 2, RW = 2, VW = 39, PW = 56, IW = 32, DEP = 16;
   localparam logic [31:0] GEN = 32'h5;

   typedef struct packed {
      logic [VW-1:0]         vaddr;
      logic [IW-1:0]         id;
      logic [FW-1:0]         sv, recv, pf, af, iss, taken, hit;
      logic [FW-1:0][VW-1:0] btb;
      logic [FW-1:0][31:0]   data;
      logic [FW-1:0][PW-1:0] paddr;
   } ent_t;

   logic clock = 1'b0;
   logic reset;
   ent_t mq[$];
   logic exp_rv;
   logic [VW-1:0] exp_ra;
   int tests = 0;
   int fails = 0;

   ifq_multi_port_if #(.FETCH_W(FW), .NUM_RES(NR), .RES_WORDS(RW), .VADDR_W(VW),
                       .PADDR_W(PW), .ID_W(IW)) bus ();

   ifq_multi_port #(.DEPTH(DEP), .FETCH_W(FW), .NUM_RES(NR), .RES_WORDS(RW), .VADDR_W(VW),
                    .PADDR_W(PW), .ID_W(IW)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Slots the head entry offers to the decoder, straight from the issue rules.
   function automatic logic [FW-1:0] offered(input ent_t e);
      logic [FW-1:0] m;
      int first;
      m = '0;
`ifdef IFQ_PARTIAL_ISSUE_EN
      first = FW;
      for (int i = FW - 1; i >= 0; i--) if (e.sv[i] && !e.iss[i]) first = i;
      for (int i = first; i < FW; i++) begin
         if (!(e.sv[i] && e.recv[i])) break;
         m[i] = 1'b1;
      end
`else
      first = 0;
      if ((e.sv & e.recv) == e.sv) m = e.sv;
`endif
      return m;
   endfunction

   task automatic model_step();
      logic [FW-1:0] av;
      bit do_issue;
      ent_t t;
      if (bus.flush) begin
         mq.delete();
         exp_rv = 1'b0;
         return;
      end
      av = '0;
      do_issue = 0;
      if (mq.size() != 0) begin
         av = offered(mq[0]);
         do_issue = (av != '0) && bus.out_ready;
      end
      exp_rv = 1'b0;
      if (bus.alloc_valid && mq.size() < DEP) begin
         t = '0;
         t.vaddr = bus.alloc_vaddr;
         t.id = bus.alloc_id;
         t.taken = bus.alloc_taken;
         t.hit = bus.alloc_btb_hit;
         t.btb = bus.alloc_btb_addr;
         for (int i = 0; i < FW; i++) begin
            t.sv[i] = 1'b1;
            if (t.taken[i] && t.hit[i]) begin
               exp_rv = 1'b1;
               exp_ra = t.btb[i];
               break;
            end
         end
         mq.push_back(t);
      end
      for (int p = 0; p < NR; p++) begin
         if (bus.res_valid[p] && bus.res_gen[p*32 +: 32] == bus.generation) begin
            for (int w = 0; w < RW; w++) begin
               logic [VW-1:0] wv;
               logic [IW-1:0] rid;
               wv  = bus.res_vaddr[p*VW +: VW] + VW'(4 * w);
               rid = bus.res_id[p*IW +: IW];
               for (int e = 0; e < mq.size(); e++) begin
                  t = mq[e];
                  for (int i = 0; i < FW; i++) begin
                     if (t.id[IW-1:2] == rid[IW-1:2] && t.vaddr + VW'(4 * i) == wv) begin
                        t.recv[i]  = 1'b1;
                        t.data[i]  = bus.res_data[(p*RW+w)*32 +: 32];
                        t.paddr[i] = bus.res_paddr[p*PW +: PW] + PW'(4 * w);
                        t.pf[i]    = bus.res_pf[p];
                        t.af[i]    = bus.res_af[p];
                     end
                  end
                  mq[e] = t;
               end
            end
         end
      end
      if (do_issue) begin
         t = mq[0];
         t.iss = t.iss | av;
         if ((t.sv & ~t.iss) == '0) void'(mq.pop_front());
         else mq[0] = t;
      end
   endtask

   task automatic check_outputs();
      logic [FW-1:0] av;
      ent_t h;
      check("alloc_ready", bus.alloc_ready, mq.size() != DEP);
      check("redirect_valid", bus.redirect_valid, exp_rv);
      if (exp_rv) check("redirect_addr", bus.redirect_addr, exp_ra);
      av = '0;
      if (mq.size() != 0) begin
         h = mq[0];
         av = offered(h);
      end
      check("out_valid", bus.out_valid, av != '0);
      if (av != '0) begin
         check("out_slot_valid", bus.out_slot_valid, av);
         check("out_pf", bus.out_pf & av, h.pf & av);
         check("out_af", bus.out_af & av, h.af & av);
         check("out_taken", bus.out_taken & av, h.taken & av);
         for (int i = 0; i < FW; i++) begin
            if (av[i]) begin
               check($sformatf("out_data[%0d]", i), bus.out_data[i*32 +: 32], h.data[i]);
               check($sformatf("out_paddr[%0d]", i), bus.out_paddr[i*PW +: PW], h.paddr[i]);
               check($sformatf("out_vaddr[%0d]", i), bus.out_vaddr[i*VW +: VW],
                     h.vaddr + VW'(4 * i));
            end
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clock);
      #1;
      check_outputs();
   endtask

   task automatic idle();
      bus.flush = 1'b0; bus.generation = GEN; bus.alloc_valid = 1'b0; bus.alloc_vaddr = '0;
      bus.alloc_id = '0; bus.alloc_taken = '0; bus.alloc_btb_hit = '0; bus.alloc_btb_addr = '0;
      bus.res_valid = '0; bus.res_id = '0; bus.res_gen = '0; bus.res_vaddr = '0;
      bus.res_paddr = '0; bus.res_pf = '0; bus.res_af = '0; bus.res_data = '0;
      bus.out_ready = 1'b0;
   endtask

   task automatic do_alloc(input logic [VW-1:0] va, input logic [IW-1:0] id,
                           input logic [FW-1:0] tk, input logic [FW-1:0] hit,
                           input logic [FW*VW-1:0] btb);
      bus.alloc_valid = 1'b1; bus.alloc_vaddr = va; bus.alloc_id = id;
      bus.alloc_taken = tk; bus.alloc_btb_hit = hit; bus.alloc_btb_addr = btb;
   endtask

   task automatic do_res(input int p, input logic [IW-1:0] id, input logic [VW-1:0] va,
                         input logic [PW-1:0] pa, input logic [63:0] d, input logic pf,
                         input logic [31:0] gen);
      bus.res_valid[p] = 1'b1;
      bus.res_id[p*IW +: IW] = id;
      bus.res_gen[p*32 +: 32] = gen;
      bus.res_vaddr[p*VW +: VW] = va;
      bus.res_paddr[p*PW +: PW] = pa;
      bus.res_pf[p] = pf;
      bus.res_af[p] = 1'b0;
      bus.res_data[p*RW*32 +: 64] = d;
   endtask

   initial begin
      logic [FW*VW-1:0] btb;
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      exp_rv = 1'b0;
      exp_ra = '0;
      check_outputs();
      check("reset_redirect_addr", bus.redirect_addr, 0);

      // 1: plain entry filled by two ports, response id differs only in the low bits
      do_alloc(39'h1000, 32'h40, 4'b0000, 4'b0000, '0);
      cycle();
      idle();
      do_res(0, 32'h41, 39'h1000, 56'h8000, 64'h00000022_00000011, 1'b0, GEN);
      do_res(1, 32'h41, 39'h1008, 56'h8008, 64'h00000044_00000033, 1'b0, GEN);
      cycle();
      check("t1_out_valid", bus.out_valid, 1);
      check("t1_slots", bus.out_slot_valid, 4'hf);
      check("t1_data_lo", bus.out_data[63:0], 64'h00000022_00000011);
      check("t1_data_hi", bus.out_data[127:64], 64'h00000044_00000033);
      idle();
      bus.out_ready = 1'b1;
      cycle();

      // 2: predicted-taken at slot 1 truncates the entry and redirects
      idle();
      btb = '0;
      btb[1*VW +: VW] = 39'h2000;
      btb[3*VW +: VW] = 39'h3000;
      do_alloc(39'h1100, 32'h80, 4'b1010, 4'b1010, btb);
      cycle();
      check("t2_redirect_valid", bus.redirect_valid, 1);
      check("t2_redirect_addr", bus.redirect_addr, 39'h2000);
      idle();
      do_res(0, 32'h80, 39'h1100, 56'h9000, 64'h0000aaaa_00005555, 1'b0, GEN);
      cycle();
      check("t2_slots", bus.out_slot_valid, 4'b0011);
      idle();
      bus.out_ready = 1'b1;
      cycle();

      // 3: fill to full with same-cycle responses, then pop/alloc around the full boundary
      for (int k = 0; k < DEP; k++) begin
         idle();
         do_alloc(39'h3000 + VW'(16 * k), 32'h100 + 32'(4 * k), '0, '0, '0);
         do_res(0, 32'h100 + 32'(4 * k), 39'h3000 + VW'(16 * k), 56'(k) << 8, {32'(k), 32'h1}, 1'b0, GEN);
         do_res(1, 32'h100 + 32'(4 * k), 39'h3008 + VW'(16 * k), 56'(k) << 9, {32'(k), 32'h2}, 1'b0, GEN);
         cycle();
      end
      check("t3_full_ready", bus.alloc_ready, 0);
      idle();
      do_alloc(39'h5000, 32'h500, '0, '0, '0);
      cycle();
      bus.out_ready = 1'b1;
      cycle();
      idle();
      do_alloc(39'h5010, 32'h510, '0, '0, '0);
      do_res(0, 32'h510, 39'h5010, 56'h5010, 64'h1, 1'b0, GEN);
      do_res(1, 32'h510, 39'h5018, 56'h5018, 64'h2, 1'b0, GEN);
      bus.out_ready = 1'b1;
      cycle();
      check("t3_alloc_pop_ready", bus.alloc_ready, 1);
      idle();
      do_alloc(39'h5020, 32'h520, '0, '0, '0);
      do_res(0, 32'h520, 39'h5020, 56'h5020, 64'h3, 1'b0, GEN);
      do_res(1, 32'h520, 39'h5028, 56'h5028, 64'h4, 1'b0, GEN);
      cycle();
      check("t3_refull_ready", bus.alloc_ready, 0);
      idle();
      bus.out_ready = 1'b1;
      repeat (DEP + 2) cycle();

      // 4: stale-generation response ignored; flush discards entries and same-cycle traffic
      idle();
      do_alloc(39'h6000, 32'h300, '0, '0, '0);
      cycle();
      idle();
      do_res(0, 32'h300, 39'h6000, 56'h6000, 64'h7, 1'b0, GEN + 1);
      do_res(1, 32'h300, 39'h6008, 56'h6008, 64'h8, 1'b0, GEN + 1);
      cycle();
      check("t4_stale_gen", bus.out_valid, 0);
      idle();
      do_alloc(39'h6010, 32'h310, '0, '0, '0);
      cycle();
      do_alloc(39'h6020, 32'h320, '0, '0, '0);
      cycle();
      idle();
      bus.flush = 1'b1;
      do_alloc(39'h6030, 32'h330, 4'b0001, 4'b0001, '0);
      do_res(0, 32'h300, 39'h6000, 56'h6000, 64'h7, 1'b0, GEN);
      do_res(1, 32'h300, 39'h6008, 56'h6008, 64'h8, 1'b0, GEN);
      cycle();
      check("t4_flush_out_valid", bus.out_valid, 0);
      check("t4_flush_ready", bus.alloc_ready, 1);
      idle();
      do_res(0, 32'h300, 39'h6000, 56'h6000, 64'h7, 1'b0, GEN);
      do_res(1, 32'h300, 39'h6008, 56'h6008, 64'h8, 1'b0, GEN);
      cycle();

      // 5: page fault on slots 0-1 still completes the entry
      idle();
      do_alloc(39'h7000, 32'h400, '0, '0, '0);
      cycle();
      idle();
      do_res(0, 32'h400, 39'h7000, 56'h7000, 64'h0, 1'b1, GEN);
      do_res(1, 32'h400, 39'h7008, 56'h7008, 64'h9, 1'b0, GEN);
      cycle();
      check("t5_out_valid", bus.out_valid, 1);
      check("t5_out_pf", bus.out_pf, 4'b0011);
      idle();
      bus.out_ready = 1'b1;
      cycle();

`ifdef IFQ_PARTIAL_ISSUE_EN
      // 6: issue slots 0-1 first, then 2-3, then the entry pops
      idle();
      do_alloc(39'h7100, 32'h410, '0, '0, '0);
      cycle();
      idle();
      do_res(0, 32'h410, 39'h7100, 56'h7100, 64'h0000000b_0000000a, 1'b0, GEN);
      cycle();
      check("t6_first_slots", bus.out_slot_valid, 4'b0011);
      bus.out_ready = 1'b1;
      idle();
      bus.out_ready = 1'b1;
      cycle();
      check("t6_wait", bus.out_valid, 0);
      idle();
      do_res(1, 32'h410, 39'h7108, 56'h7108, 64'h0000000d_0000000c, 1'b0, GEN);
      cycle();
      check("t6_second_slots", bus.out_slot_valid, 4'b1100);
      idle();
      bus.out_ready = 1'b1;
      cycle();
      check("t6_popped", bus.out_valid, 0);
`endif

      // Random traffic over a small address/id pool so entries collide and wrap.
      for (int c = 0; c < 800; c++) begin
         idle();
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.flush = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 2) != 0) begin
            btb = '0;
            for (int i = 0; i < FW; i++) btb[i*VW +: VW] = VW'({$urandom, $urandom});
            do_alloc(39'h4000 + VW'(16 * $urandom_range(0, 7)), 32'h200 + 32'(4 * $urandom_range(0, 7)),
                     FW'($urandom_range(0, 15) & $urandom_range(0, 15)), FW'($urandom_range(0, 15)),
                     btb);
         end
         for (int p = 0; p < NR; p++) begin
            if ($urandom_range(0, 1) != 0) begin
               logic [VW-1:0] base;
               logic [IW-1:0] id;
               if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
                  int k;
                  k = $urandom_range(0, mq.size() - 1);
                  base = mq[k].vaddr;
                  id = mq[k].id;
               end else begin
                  base = 39'h4000 + VW'(16 * $urandom_range(0, 7));
                  id = 32'h200 + 32'(4 * $urandom_range(0, 7));
               end
               do_res(p, id | 32'($urandom_range(0, 3)), base + VW'(4 * $urandom_range(0, 3)),
                      PW'({$urandom, $urandom}), {$urandom, $urandom}, ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 7) == 0) ? GEN + 1 : GEN);
               bus.res_af[p] = ($urandom_range(0, 9) == 0);
            end
         end
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
